// File: rtl/cache_pkg.sv
// Shared constants, refill FSM encoding and address-field width helpers for the cache.
// Used by the refill engine, the tag array and the byte-offset mux.
package cache_pkg;

    localparam int         LINE_BYTES     = 8;
    localparam int         OFFSET_W       = 3;
    localparam logic [7:0] BURST_LEN      = 8'd7;

    localparam logic [2:0] AXI_SIZE_1B    = 3'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - OFFSET_W;
    endfunction

    function automatic int index_lsb();
        return OFFSET_W;
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Assembles byte beats into a cache line: lane k takes the k-th accepted beat.
// Once lane 7 is written the buffer saturates and ignores further beats until cleared.
module refill_line_buffer
    import cache_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [7:0]                wr_data,
    output logic [8*LINE_BYTES-1:0]   line,
    output logic [OFFSET_W-1:0]       beat_cnt,
    output logic                      full
);

    localparam logic [OFFSET_W-1:0] LAST_LANE = OFFSET_W'(LINE_BYTES - 1);

    logic [OFFSET_W-1:0] cnt_reg;
    logic                full_reg;
    logic                lane_we;

    assign lane_we = wr_en && !full_reg;

    generate
        for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    lane_reg <= '0;
                end else if (lane_we && (cnt_reg == OFFSET_W'(gi))) begin
                    lane_reg <= wr_data;
                end
            end

            assign line[8*gi +: 8] = lane_reg;
        end
    endgenerate

    // The counter parks on the last lane instead of wrapping; full marks it consumed.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else if (lane_we) begin
            if (cnt_reg == LAST_LANE) begin
                full_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign beat_cnt = cnt_reg;
    assign full     = full_reg;

endmodule

// File: rtl/line_refill_unit.sv
// Cache miss refill engine: one 8-beat byte-wide INCR burst per miss, then a
// single-cycle fill strobe carrying the assembled line, index, tag and error flag.
module line_refill_unit
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4
)
(
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic                                  miss_valid,
    output logic                                  miss_ready,
    input  logic [ADDR_W-1:0]                     miss_addr,

    output logic                                  m_ARVALID,
    input  logic                                  m_ARREADY,
    output logic [ADDR_W-1:0]                     m_ARADDR,
    output logic [7:0]                            m_ARLEN,
    output logic [2:0]                            m_ARSIZE,
    output logic [1:0]                            m_ARBURST,

    input  logic                                  m_RVALID,
    output logic                                  m_RREADY,
    input  logic [7:0]                            m_RDATA,
    input  logic [1:0]                            m_RRESP,
    input  logic                                  m_RLAST,

    output logic                                  fill_valid,
    output logic [8*LINE_BYTES-1:0]               fill_line,
    output logic [INDEX_W-1:0]                    fill_index,
    output logic [tag_width(ADDR_W, INDEX_W)-1:0] fill_tag,
    output logic                                  fill_err
);

    localparam int TAG_W  = tag_width(ADDR_W, INDEX_W);
    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_LANE = OFFSET_W'(LINE_BYTES - 1);

    refill_state_t       state_reg;
    logic [LINE_W-1:0]   line_addr_reg;
    logic                miss_ready_reg;
    logic                arvalid_reg;
    logic                rready_reg;
    logic                fill_valid_reg;
    logic                fill_err_reg;
    logic                err_reg;

    logic                accept;
    logic                beat;
    logic                beat_err;
    logic [OFFSET_W-1:0] beat_cnt;
    logic                buf_full;
    logic                unused_offset;

    assign unused_offset = ^miss_addr[OFFSET_W-1:0];

    assign accept = (state_reg == IDLE) && miss_ready_reg && miss_valid;
    assign beat   = (state_reg == DATA) && rready_reg && m_RVALID;

    refill_line_buffer u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .wr_en    (beat),
        .wr_data  (m_RDATA),
        .line     (fill_line),
        .beat_cnt (beat_cnt),
        .full     (buf_full)
    );

    // A burst is bad if any response is not OKAY or RLAST misses the 8th beat.
    always_comb begin
        beat_err = 1'b0;
        if (beat) begin
            if (m_RRESP != AXI_RESP_OKAY) begin
                beat_err = 1'b1;
            end
            if (!buf_full && (beat_cnt != LAST_LANE) && m_RLAST) begin
                beat_err = 1'b1;
            end
            if (!buf_full && (beat_cnt == LAST_LANE) && !m_RLAST) begin
                beat_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            line_addr_reg  <= '0;
            miss_ready_reg <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            fill_valid_reg <= 1'b0;
            fill_err_reg   <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    miss_ready_reg <= 1'b1;
                    if (accept) begin
                        line_addr_reg  <= miss_addr[ADDR_W-1:OFFSET_W];
                        miss_ready_reg <= 1'b0;
                        arvalid_reg    <= 1'b1;
                        err_reg        <= 1'b0;
                        state_reg      <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        err_reg <= err_reg | beat_err;
                        if (m_RLAST) begin
                            rready_reg     <= 1'b0;
                            fill_valid_reg <= 1'b1;
                            fill_err_reg   <= err_reg | beat_err;
                            state_reg      <= DONE;
                        end
                    end
                end
                DONE: begin
                    fill_valid_reg <= 1'b0;
                    fill_err_reg   <= 1'b0;
                    miss_ready_reg <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign miss_ready = miss_ready_reg;
    assign m_ARVALID  = arvalid_reg;
    assign m_ARADDR   = {line_addr_reg, {OFFSET_W{1'b0}}};
    assign m_ARLEN    = BURST_LEN;
    assign m_ARSIZE   = AXI_SIZE_1B;
    assign m_ARBURST  = AXI_BURST_INCR;
    assign m_RREADY   = rready_reg;
    assign fill_valid = fill_valid_reg;
    assign fill_err   = fill_err_reg;
    assign fill_index = line_addr_reg[INDEX_W-1:0];
    assign fill_tag   = line_addr_reg[LINE_W-1 -: TAG_W];

endmodule

// File: tb/tb_line_refill_unit.sv
// Randomized bench for line_refill_unit: an AXI slave model feeds bursts and a
// transaction-level model predicts the filled line, error flag and timing.
module tb_line_refill_unit;

    localparam int ADDR_W  = 32;
    localparam int INDEX_W = 4;
    localparam int TAG_W   = ADDR_W - INDEX_W - 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               miss_valid;
    logic               miss_ready;
    logic [ADDR_W-1:0]  miss_addr;
    logic               m_ARVALID;
    logic               m_ARREADY;
    logic [ADDR_W-1:0]  m_ARADDR;
    logic [7:0]         m_ARLEN;
    logic [2:0]         m_ARSIZE;
    logic [1:0]         m_ARBURST;
    logic               m_RVALID;
    logic               m_RREADY;
    logic [7:0]         m_RDATA;
    logic [1:0]         m_RRESP;
    logic               m_RLAST;
    logic               fill_valid;
    logic [63:0]        fill_line;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic               fill_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] bdata [16];
    logic [1:0] bresp [16];

    always #5 clk = ~clk;

    line_refill_unit #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_ready (miss_ready),
        .miss_addr  (miss_addr),
        .m_ARVALID  (m_ARVALID),
        .m_ARREADY  (m_ARREADY),
        .m_ARADDR   (m_ARADDR),
        .m_ARLEN    (m_ARLEN),
        .m_ARSIZE   (m_ARSIZE),
        .m_ARBURST  (m_ARBURST),
        .m_RVALID   (m_RVALID),
        .m_RREADY   (m_RREADY),
        .m_RDATA    (m_RDATA),
        .m_RRESP    (m_RRESP),
        .m_RLAST    (m_RLAST),
        .fill_valid (fill_valid),
        .fill_line  (fill_line),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_err   (fill_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_miss_ready"}, 64'(miss_ready), 64'd0);
        check_val({tag, "_arvalid"},    64'(m_ARVALID),  64'd0);
        check_val({tag, "_araddr"},     64'(m_ARADDR),   64'd0);
        check_val({tag, "_rready"},     64'(m_RREADY),   64'd0);
        check_val({tag, "_fill_valid"}, 64'(fill_valid), 64'd0);
        check_val({tag, "_fill_err"},   64'(fill_err),   64'd0);
        check_val({tag, "_fill_line"},  fill_line,       64'd0);
        check_val({tag, "_fill_index"}, 64'(fill_index), 64'd0);
        check_val({tag, "_fill_tag"},   64'(fill_tag),   64'd0);
    endtask

    // n beats with RLAST on beat n-1; gap_mode 0=none, 1=random, 2=every other cycle.
    task automatic run_refill(input logic [31:0] addr, input int n, input int ar_wait,
                              input int gap_mode, input int abort_beat, input bit hold_valid);
        int          c;
        int          bidx;
        int          arv_cycles;
        int          hs_cycle;
        int          last_cycle;
        bit          ar_done;
        bit          fill_seen;
        bit          give;
        logic [63:0] exp_line;
        bit          exp_err;

        exp_line = '0;
        exp_err  = (n != 8);
        for (int k = 0; k < n; k++) begin
            if (k < 8) exp_line[8*k +: 8] = bdata[k];
            if (bresp[k] != 2'b00) exp_err = 1'b1;
        end

        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr  = addr;
        c = 0;
        while (!miss_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_val("accept_ready", 64'(miss_ready), 64'd1);

        c = 0; bidx = 0; arv_cycles = 0; hs_cycle = -1; last_cycle = -1;
        ar_done = 1'b0; fill_seen = 1'b0;
        while (!fill_seen && c < 300) begin
            @(negedge clk);
            c++;
            if (!hold_valid) miss_valid = 1'b0;
            m_ARREADY = 1'b0;
            m_RVALID  = 1'b0;
            m_RLAST   = 1'b0;
            m_RDATA   = 8'($urandom);
            m_RRESP   = 2'($urandom);
            check_val("busy_ready", 64'(miss_ready), 64'd0);
            if (fill_valid) begin
                fill_seen = 1'b1;
                check_val("fill_line",  fill_line,       exp_line);
                check_val("fill_err",   64'(fill_err),   64'(exp_err));
                check_val("fill_index", 64'(fill_index), 64'((addr >> 3) & 32'hF));
                check_val("fill_tag",   64'(fill_tag),   64'(addr >> 7));
                check_val("fill_cycle", 64'(c),          64'(last_cycle + 1));
                if (gap_mode == 0) check_val("fill_latency", 64'(c), 64'(2 + ar_wait + n));
            end else if (!ar_done) begin
                check_val("arvalid", 64'(m_ARVALID), 64'd1);
                check_val("araddr",  64'(m_ARADDR),  64'(addr & 32'hFFFF_FFF8));
                check_val("arlen",   64'(m_ARLEN),   64'd7);
                check_val("arsize",  64'(m_ARSIZE),  64'd0);
                check_val("arburst", 64'(m_ARBURST), 64'd1);
                check_val("rready_early", 64'(m_RREADY), 64'd0);
                if (arv_cycles >= ar_wait) begin
                    m_ARREADY = 1'b1;
                    ar_done   = 1'b1;
                    hs_cycle  = c;
                end
                arv_cycles++;
            end else begin
                if (c == hs_cycle + 1) begin
                    check_val("rready_rise", 64'(m_RREADY),  64'd1);
                    check_val("arvalid_off", 64'(m_ARVALID), 64'd0);
                end
                if (last_cycle >= 0) check_val("fill_missing", 64'(fill_valid), 64'd1);
                if (abort_beat >= 0 && bidx == abort_beat) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_reset_outputs("abort");
                    rst = 1'b0;
                    miss_valid = 1'b0;
                    @(negedge clk);
                    check_val("abort_ready", 64'(miss_ready), 64'd1);
                    $display("refill addr=%08h aborted by reset at beat %0d", addr, bidx);
                    return;
                end
                if (m_RREADY && bidx < n) begin
                    case (gap_mode)
                        0:       give = 1'b1;
                        1:       give = ($urandom_range(0, 1) == 1);
                        default: give = (c % 2 == 0);
                    endcase
                    if (give) begin
                        m_RVALID = 1'b1;
                        m_RDATA  = bdata[bidx];
                        m_RRESP  = bresp[bidx];
                        m_RLAST  = (bidx == n - 1);
                        bidx++;
                        if (bidx == n) last_cycle = c;
                    end
                end
            end
        end
        if (!fill_seen) check_val("fill_timeout", 64'd0, 64'd1);

        @(negedge clk);
        miss_valid = 1'b0;
        m_RVALID   = 1'b0;
        m_RLAST    = 1'b0;
        check_val("fill_pulse",  64'(fill_valid), 64'd0);
        check_val("ready_again", 64'(miss_ready), 64'd1);
        check_val("rready_off",  64'(m_RREADY),   64'd0);
        $display("refill addr=%08h beats=%0d arwait=%0d gap=%0d line=%016h err=%0d expected line=%016h err=%0d",
                 addr, n, ar_wait, gap_mode, fill_line, fill_err, exp_line, exp_err);
    endtask

    task automatic set_beats(input int mode, input logic [7:0] base);
        for (int k = 0; k < 16; k++) begin
            bdata[k] = (mode == 0) ? 8'(base + 8'(k)) : 8'($urandom);
            bresp[k] = 2'b00;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        m_ARREADY  = 1'b0;
        m_RVALID   = 1'b0;
        m_RDATA    = '0;
        m_RRESP    = '0;
        m_RLAST    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_val("post_reset_ready", 64'(miss_ready), 64'd1);

        set_beats(0, 8'h10);
        run_refill(32'h0000_1235, 8, 0, 0, -1, 1'b0);
        run_refill(32'h0000_1235, 8, 3, 2, -1, 1'b0);

        set_beats(1, 8'h00);
        bresp[4] = 2'b10;
        run_refill($urandom, 8, 0, 0, -1, 1'b0);

        set_beats(0, 8'hA0);
        run_refill(32'h0000_4448, 6, 0, 0, -1, 1'b0);
        check_val("rlast5_line", fill_line, 64'h0000_A5A4_A3A2_A1A0);

        set_beats(1, 8'h00);
        run_refill($urandom, 10, 1, 0, -1, 1'b0);

        set_beats(1, 8'h00);
        run_refill(32'hDEAD_BEEF, 8, 0, 0, 3, 1'b0);
        set_beats(0, 8'h55);
        run_refill(32'h0000_0F08, 8, 0, 0, -1, 1'b0);

        set_beats(1, 8'h00);
        run_refill($urandom, 8, 2, 1, -1, 1'b1);

        for (int t = 0; t < 40; t++) begin
            set_beats(1, 8'h00);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 8;
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 19) == 0) bresp[k] = 2'($urandom_range(1, 3));
            end
            run_refill($urandom, n, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1,
                       1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_refill_unit.md
# line_refill_unit

Cache miss refill engine for the AXI-MM cache. On a miss it issues one 8-beat, byte-wide INCR read burst on the AXI master read channels and assembles the beats into a 64-bit line. It then presents the line, with its index and tag, for one cycle to the data/tag arrays. The line it writes is later returned as `selectedLine` and split by the byte-offset mux, so beat k lands in byte lane k (bits [8k+7:8k]).

## Interface
- `ADDR_W`, 32: byte address width
- `INDEX_W`, 4: set index width; tag width = `ADDR_W-INDEX_W-3`
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `miss_valid` in 1: miss request
- `miss_ready` out 1: refill unit idle, request accepted when both high
- `miss_addr` in ADDR_W: miss byte address; bits [2:0] ignored
- `m_ARVALID` out 1, `m_ARREADY` in 1: AR handshake
- `m_ARADDR` out ADDR_W: line-aligned address (`{miss_addr[ADDR_W-1:3],3'b0}`)
- `m_ARLEN` out 8 (constant 7), `m_ARSIZE` out 3 (constant 0), `m_ARBURST` out 2 (constant 2'b01 INCR)
- `m_RVALID` in 1, `m_RREADY` out 1: R handshake
- `m_RDATA` in 8, `m_RRESP` in 2, `m_RLAST` in 1: read beat
- `fill_valid` out 1: one-cycle write strobe to the arrays
- `fill_line` out 64: assembled line
- `fill_index` out INDEX_W, `fill_tag` out ADDR_W-INDEX_W-3: from latched address
- `fill_err` out 1: line is unreliable; arrays must leave valid bit clear

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: `miss_ready`=1. On `miss_valid`, latch `miss_addr`, clear line buffer, beat counter and error flag, then go to ADDR.
- ADDR: `m_ARVALID`=1 with stable `m_ARADDR`, held until `m_ARREADY`. The handshake cycle moves the FSM to DATA.
- DATA: `m_RREADY`=1. Each beat with `m_RVALID` writes `m_RDATA` into lane `beat_cnt` (3-bit counter, 0..7) and increments the counter. `m_RRESP`≠2'b00 on any beat sets the sticky error.
- DATA exit is on `m_RLAST`:
  - RLAST on beat 7: normal completion, go to DONE.
  - RLAST before beat 7: set error, unfilled lanes stay 0, go to DONE.
  - Beat 7 without RLAST: set error, keep `m_RREADY`=1, discard further beats (no counter wrap, no lane overwrite) until RLAST, then go to DONE.
- DONE: `fill_valid`=1 for exactly one cycle; `fill_line`/`fill_index`/`fill_tag`/`fill_err` are valid that cycle. Return to IDLE.
- Only one refill is outstanding at a time. No new miss is accepted until IDLE.

## Timing
- Reset values: `miss_ready`=0 during reset, 1 the cycle after reset deasserts. `m_ARVALID`=0, `m_RREADY`=0, `fill_valid`=0, `fill_err`=0, `fill_line`=0, `fill_index`=0, `fill_tag`=0, `m_ARADDR`=0. State is IDLE.
- All outputs are registered or decoded from the state register only; there is no combinational path from AXI inputs to AXI outputs.
- Minimum latency, counting the accept cycle as 0 with `m_ARREADY` and `m_RVALID` held high:
  - AR handshake at cycle 1.
  - Beats at cycles 2–9.
  - `fill_valid` at cycle 10.
  - `miss_ready` high again at cycle 11.
- `m_RREADY` rises the cycle after the AR handshake. It never depends on `m_RVALID`.
- RVALID gaps only stall the counter. Lane order is unaffected.
- `rst` mid-refill returns the FSM to IDLE next cycle with all outputs at reset values. Any burst still in flight is abandoned; the memory side is reset in the same domain.

## Structure
- `cache_pkg` holds:
  - `LINE_BYTES`=8, `OFFSET_W`=3, `BURST_LEN`=8'd7
  - `AXI_SIZE_1B`=3'd0, `AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00
  - the `refill_state_t` enum
  - the tag/index width functions shared with the tag array and the byte-offset mux
- One sub-module: `refill_line_buffer`. It contains the 64-bit lane-write register, the beat counter, the saturation-at-7 logic and the clear input. The top level keeps the FSM and AXI signalling.

## Test plan
- Miss at 0x0000_1235 with a zero-wait slave returning bytes 0x10..0x17 → ARADDR=0x0000_1230, ARLEN=7, ARSIZE=0, ARBURST=1. `fill_line`=0x1716151413121110, `fill_valid` at cycle 10, `fill_err`=0.
- Same miss with RVALID toggled every other cycle and ARREADY delayed 3 cycles → ARVALID stays stable while waiting, same `fill_line`, fill delayed accordingly.
- RRESP=2'b10 on beat 4 only → all 8 lanes still written, `fill_err`=1.
- RLAST on beat 5 (bytes 0xA0..0xA5) → `fill_line`=0x0000A5A4A3A2A1A0, `fill_err`=1. A 10-beat burst → lanes hold beats 0–7, `fill_err`=1, fill occurs after the 10th beat.
- `rst` asserted at beat 3 → all outputs at reset values next cycle. A new miss afterwards completes normally with no residual bytes from the aborted fill.
- `miss_valid` held high continuously → exactly one accept per refill. `miss_ready` is low from the cycle after accept through DONE.
